huffman_dc_bit_packer: RTL and testbench

Packs Huffman-coded DC tuples into a JPEG entropy-coded byte stream. It sits directly downstream of the DC Huffman encoder stage and consumes that stage's registered 24-bit tuple:

- code bits, MSB-aligned;
- code length;
- amplitude bits.

It concatenates the code bits with the amplitude bits MSB-first into a bit accumulator, emits whole bytes with 0xFF→0xFF 0x00 stuffing, and on request pads the final partial byte with 1s.

---
 rtl/jpeg_enc_pkg.sv | 20 ++
 rtl/huff_field_merge.sv | 39 +++
 rtl/huffman_dc_bit_packer.sv | 126 ++++++++++++
 tb/tb_huffman_dc_bit_packer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_enc_pkg.sv
// Shared definitions for the JPEG entropy-coding stages.
// Tuple layout, accumulator sizing, marker bytes and packer states.
package jpeg_enc_pkg;

    localparam int CODE_MSB       = 23;
    localparam int LEN_MSB        = 15;
    localparam int AMP_MSB        = 7;
    localparam int MAX_FIELD_BITS = 16;
    localparam int ACC_BITS       = 32;

    localparam logic [7:0] STUFF_BYTE  = 8'h00;
    localparam logic [7:0] MARKER_BYTE = 8'hFF;

    typedef enum logic [1:0] {
        RUN,
        PAD,
        DRAIN
    } state_t;

endpackage

// File: rtl/huff_field_merge.sv
// Builds the MSB-aligned code+amplitude bit field of one DC tuple.
// Lengths above 8 are clamped; unused bits of each part are masked off.
module huff_field_merge
    import jpeg_enc_pkg::*;
(
    input  logic [23:0]               in_data,
    input  logic [3:0]                in_size,
    output logic [MAX_FIELD_BITS-1:0] field,
    output logic [4:0]                field_len
);

    logic [7:0]  code;
    logic [7:0]  len_raw;
    logic [7:0]  amp;
    logic [3:0]  code_len;
    logic [3:0]  amp_len;
    logic [7:0]  code_mask;
    logic [7:0]  amp_mask;
    logic [15:0] code_part;
    logic [15:0] amp_top;
    logic [15:0] amp_part;

    // Clamp both lengths, mask the fields and butt them together MSB-first
    always_comb begin
        code      = in_data[CODE_MSB -: 8];
        len_raw   = in_data[LEN_MSB -: 8];
        amp       = in_data[AMP_MSB -: 8];
        code_len  = (len_raw > 8'd8) ? 4'd8 : len_raw[3:0];
        amp_len   = (in_size > 4'd8) ? 4'd8 : in_size;
        code_mask = ~(8'hFF >> code_len);
        amp_mask  = ~(8'hFF << amp_len);
        code_part = {code & code_mask, 8'h00};
        amp_top   = {amp & amp_mask, 8'h00} << (4'd8 - amp_len);
        amp_part  = amp_top >> code_len;
        field     = code_part | amp_part;
        field_len = {1'b0, code_len} + {1'b0, amp_len};
    end

endmodule

// File: rtl/huffman_dc_bit_packer.sv
// Packs DC Huffman fields into a byte stream with 0xFF stuffing.
// Flush pads the last partial byte with 1s and drains the accumulator.
module huffman_dc_bit_packer
    import jpeg_enc_pkg::*;
#(
    parameter bit STUFF_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_data,
    input  logic [3:0]  in_size,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        flush_done
);

    state_t                      state;
    state_t                      state_next;
    logic [ACC_BITS-1:0]         acc;
    logic [ACC_BITS-1:0]         acc_next;
    logic [ACC_BITS-1:0]         acc_sh;
    logic [5:0]                  cnt;
    logic [5:0]                  cnt_next;
    logic [5:0]                  cnt_sh;
    logic [5:0]                  rnd;
    logic                        stuff_pend;
    logic                        stuff_next;
    logic                        ov_next;
    logic [7:0]                  od_next;
    logic                        fd_next;
    logic                        load;
    logic                        extract;
    logic                        accept;
    logic [MAX_FIELD_BITS-1:0]   field;
    logic [4:0]                  field_len;

    huff_field_merge u_merge (
        .in_data   (in_data),
        .in_size   (in_size),
        .field     (field),
        .field_len (field_len)
    );

    assign in_ready = (state == RUN) && (cnt <= 6'd16);
    assign accept   = in_valid && in_ready;

    // Output loading, byte extraction, append/pad and state sequencing
    always_comb begin
        load       = (!out_valid || out_ready) && (stuff_pend || cnt >= 6'd8);
        extract    = load && !stuff_pend;
        acc_sh     = extract ? (acc << 8) : acc;
        cnt_sh     = extract ? (cnt - 6'd8) : cnt;
        rnd        = {cnt_sh[5:3] + {2'b00, |cnt_sh[2:0]}, 3'b000};
        ov_next    = out_valid && !out_ready;
        od_next    = out_data;
        stuff_next = stuff_pend;
        acc_next   = acc_sh;
        cnt_next   = cnt_sh;
        state_next = state;
        fd_next    = 1'b0;

        if (load) begin
            ov_next = 1'b1;
            if (stuff_pend) begin
                od_next    = STUFF_BYTE;
                stuff_next = 1'b0;
            end else begin
                od_next = acc[31:24];
                if (STUFF_EN && acc[31:24] == MARKER_BYTE) begin
                    stuff_next = 1'b1;
                end
            end
        end

        unique case (state)
            RUN: begin
                if (accept) begin
                    acc_next = acc_sh | ({field, 16'h0000} >> cnt_sh);
                    cnt_next = cnt_sh + {1'b0, field_len};
                end
                if (flush && !accept) begin
                    state_next = PAD;
                end
            end
            PAD: begin
                acc_next   = acc_sh | ((32'hFFFF_FFFF >> cnt_sh)
                                     & ~(32'hFFFF_FFFF >> rnd));
                cnt_next   = rnd;
                state_next = DRAIN;
            end
            DRAIN: begin
                if (cnt == 6'd0 && !stuff_pend && (!out_valid || out_ready)) begin
                    fd_next    = 1'b1;
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // State, accumulator and output holding register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            acc        <= '0;
            cnt        <= '0;
            stuff_pend <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= 8'h00;
            flush_done <= 1'b0;
        end else begin
            state      <= state_next;
            acc        <= acc_next;
            cnt        <= cnt_next;
            stuff_pend <= stuff_next;
            out_valid  <= ov_next;
            out_data   <= od_next;
            flush_done <= fd_next;
        end
    end

endmodule

// File: tb/tb_huffman_dc_bit_packer.sv
// Directed bench for huffman_dc_bit_packer, stuffing on and off.
// Table of single-tuple+flush vectors plus multi-cycle sequences.
module tb_huffman_dc_bit_packer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [23:0] in_data;
    logic [3:0]  in_size;
    logic        flush;
    logic        out_ready;
    logic        in_ready0, in_ready1;
    logic        out_valid0, out_valid1;
    logic [7:0]  out_data0, out_data1;
    logic        flush_done0, flush_done1;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         t0[$];

    typedef struct {
        logic [7:0]  code;
        logic [7:0]  len;
        logic [3:0]  size;
        logic [7:0]  amp;
        int          n0;
        logic [23:0] e0;
        int          n1;
        logic [23:0] e1;
    } vec_t;

    vec_t tbl[9];

    huffman_dc_bit_packer #(.STUFF_EN(1'b1)) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready0),
        .in_data    (in_data),
        .in_size    (in_size),
        .flush      (flush),
        .out_valid  (out_valid0),
        .out_ready  (out_ready),
        .out_data   (out_data0),
        .flush_done (flush_done0)
    );

    huffman_dc_bit_packer #(.STUFF_EN(1'b0)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready1),
        .in_data    (in_data),
        .in_size    (in_size),
        .flush      (flush),
        .out_valid  (out_valid1),
        .out_ready  (out_ready),
        .out_data   (out_data1),
        .flush_done (flush_done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Collect every accepted byte of both instances
    always @(negedge clk) begin
        if (out_valid0 && out_ready) begin
            q0.push_back(out_data0);
            t0.push_back(cyc);
        end
        if (out_valid1 && out_ready) begin
            q1.push_back(out_data1);
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] code, input logic [7:0] len,
                        input logic [3:0] size, input logic [7:0] amp);
        int t;
        in_data  = {code, len, amp};
        in_size  = size;
        in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready0 && t < 100) begin
            t++;
            @(negedge clk);
        end
        if (!in_ready0) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int lat);
        int t;
        t = 0;
        lat = -1;
        @(negedge clk);
        while (!flush_done0 && t < 100) begin
            t++;
            @(negedge clk);
        end
        if (!flush_done0) begin
            chk("flush_timeout", 0, 1);
        end else begin
            lat = cyc - c0;
            @(negedge clk);
            chk("flush_done_pulse", {31'd0, flush_done0}, 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush(output int lat);
        int c0;
        c0 = cyc;
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        wait_done(c0, lat);
    endtask

    initial begin
        int lat;
        int acc_t[4];

        tbl[0] = '{8'h00, 8'd2,  4'd3,  8'h05, 1, 24'h2F0000, 1, 24'h2F0000};
        tbl[1] = '{8'hFF, 8'd8,  4'd0,  8'h00, 2, 24'hFF0000, 1, 24'hFF0000};
        tbl[2] = '{8'hA0, 8'd4,  4'd4,  8'h05, 1, 24'hA50000, 1, 24'hA50000};
        tbl[3] = '{8'h00, 8'd0,  4'd0,  8'h00, 0, 24'h000000, 0, 24'h000000};
        tbl[4] = '{8'h00, 8'd0,  4'd12, 8'hC3, 1, 24'hC30000, 1, 24'hC30000};
        tbl[5] = '{8'hC0, 8'd3,  4'd8,  8'hFF, 3, 24'hDFFF00, 2, 24'hDFFF00};
        tbl[6] = '{8'h00, 8'd1,  4'd3,  8'hFF, 1, 24'h7F0000, 1, 24'h7F0000};
        tbl[7] = '{8'h5A, 8'd8,  4'd8,  8'h5A, 2, 24'h5A5A00, 2, 24'h5A5A00};
        tbl[8] = '{8'h80, 8'd0,  4'd1,  8'h01, 2, 24'hFF0000, 1, 24'hFF0000};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_size   = '0;
        flush     = 1'b0;
        out_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid0}, 0);
        chk("rst_out_data", {24'd0, out_data0}, 0);
        chk("rst_flush_done", {30'd0, flush_done0, flush_done1}, 0);
        chk("rst_in_ready", {30'd0, in_ready0, in_ready1}, 3);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            q0.delete();
            q1.delete();
            send(tbl[i].code, tbl[i].len, tbl[i].size, tbl[i].amp);
            do_flush(lat);
            chk($sformatf("v%0d_count0", i), q0.size(), tbl[i].n0);
            chk($sformatf("v%0d_count1", i), q1.size(), tbl[i].n1);
            for (int j = 0; j < tbl[i].n0; j++) begin
                if (j < q0.size())
                    chk($sformatf("v%0d_byte0_%0d", i, j), {24'd0, q0[j]},
                        {24'd0, tbl[i].e0[23-8*j -: 8]});
            end
            for (int j = 0; j < tbl[i].n1; j++) begin
                if (j < q1.size())
                    chk($sformatf("v%0d_byte1_%0d", i, j), {24'd0, q1[j]},
                        {24'd0, tbl[i].e1[23-8*j -: 8]});
            end
            if (tbl[i].n0 == 0) chk($sformatf("v%0d_flush_lat", i), lat, 3);
        end

        q0.delete();
        t0.delete();
        in_data  = {8'hA0, 8'd4, 8'h05};
        in_size  = 4'd4;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int t;
            t = 0;
            @(negedge clk);
            while (!in_ready0 && t < 20) begin
                t++;
                @(negedge clk);
            end
            acc_t[i] = cyc;
            chk($sformatf("stream_in_ready_%0d", i), {31'd0, in_ready0}, 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("stream_count", q0.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < q0.size()) begin
                chk($sformatf("stream_byte_%0d", i), {24'd0, q0[i]}, 32'hA5);
                chk($sformatf("stream_lat_%0d", i), t0[i] - acc_t[i], 2);
            end
        end

        q0.delete();
        out_ready = 1'b0;
        send(8'h12, 8'd8, 4'd8, 8'h34);
        send(8'h12, 8'd8, 4'd8, 8'h34);
        @(negedge clk);
        chk("bp_in_ready_low", {31'd0, in_ready0}, 0);
        chk("bp_out_valid", {31'd0, out_valid0}, 1);
        chk("bp_out_data", {24'd0, out_data0}, 32'h12);
        repeat (3) @(negedge clk);
        chk("bp_hold_data", {24'd0, out_data0}, 32'h12);
        chk("bp_hold_in_ready", {31'd0, in_ready0}, 0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(8'h12, 8'd8, 4'd8, 8'h34);
        do_flush(lat);
        chk("bp_count", q0.size(), 6);
        for (int j = 0; j < 6; j++) begin
            if (j < q0.size())
                chk($sformatf("bp_byte_%0d", j), {24'd0, q0[j]},
                    (j % 2 == 0) ? 32'h12 : 32'h34);
        end

        q0.delete();
        in_data  = {8'hA0, 8'd12, 8'h01};
        in_size  = 4'd2;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        chk("fv_in_ready", {31'd0, in_ready0}, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        begin
            int c0;
            c0 = cyc;
            @(posedge clk);
            #1 flush = 1'b0;
            wait_done(c0, lat);
        end
        chk("fv_count", q0.size(), 2);
        if (q0.size() == 2) begin
            chk("fv_byte0", {24'd0, q0[0]}, 32'hA0);
            chk("fv_byte1", {24'd0, q0[1]}, 32'h7F);
        end

        out_ready = 1'b0;
        send(8'h5A, 8'd8, 4'd8, 8'h5A);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid0}, 0);
        chk("mid_rst_out_data", {24'd0, out_data0}, 0);
        chk("mid_rst_flush_done", {31'd0, flush_done0}, 0);
        chk("mid_rst_in_ready", {31'd0, in_ready0}, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        q0.delete();
        @(posedge clk);
        #1;
        send(8'h00, 8'd2, 4'd3, 8'h05);
        do_flush(lat);
        chk("post_rst_count", q0.size(), 1);
        if (q0.size() == 1) chk("post_rst_byte", {24'd0, q0[0]}, 32'h2F);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
